// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for a 3x3 Sobel core: raster-reads a source frame, builds the
// sliding window from two line buffers, and writes results at compacted addresses.
module sobel_frame_ctrl #(
  parameter int unsigned MAX_W     = 640,
  parameter int unsigned ADDR_W    = 19,
  parameter int unsigned SOBEL_LAT = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [15:0]       cfg_w,
  input  logic [15:0]       cfg_h,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              win_valid,
  output logic [7:0]        win_d0,
  output logic [7:0]        win_d1,
  output logic [7:0]        win_d2,
  output logic [7:0]        win_d3,
  output logic [7:0]        win_d4,
  output logic [7:0]        win_d5,
  output logic [7:0]        win_d6,
  output logic [7:0]        win_d7,
  output logic [7:0]        win_d8,
  input  logic [7:0]        sobel_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  localparam int unsigned CW      = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam logic [32:0] MAX_PIX = 33'(1) << ADDR_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t              state_q, state_nx;
  logic                busy_q, busy_nx;
  logic                done_q, done_nx;
  logic                cfg_err_q, cfg_err_nx;
  logic                rd_en_q, rd_en_nx;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_nx;
  logic [ADDR_W-1:0]   last_rd_q, last_rd_nx;
  logic [ADDR_W-1:0]   last_wr_q, last_wr_nx;
  logic [CW-1:0]       w_m1_q, w_m1_nx;
  logic [31:0]         npix;
  logic                cfg_ok;
  logic                start_acc;

  logic                cap_v;
  logic [CW-1:0]       col_q;
  logic [15:0]         row_q;
  logic [7:0]          win_q [9];
  logic                win_valid_q;
  logic [ADDR_W-1:0]   win_idx_q;
  logic [ADDR_W-1:0]   win_cnt_q;
  logic                dly_v   [SOBEL_LAT];
  logic [ADDR_W-1:0]   dly_idx [SOBEL_LAT];
  logic [7:0]          lb0 [MAX_W];
  logic [7:0]          lb1 [MAX_W];
  logic [7:0]          lb0_rd, lb1_rd;

  assign npix   = 32'(cfg_w) * 32'(cfg_h);
  assign cfg_ok = (cfg_w >= 16'd3) && (32'(cfg_w) <= 32'(MAX_W)) &&
                  (cfg_h >= 16'd3) && ({1'b0, npix} <= MAX_PIX);

  // Frame-level sequencing: next-state and next registered outputs
  always_comb begin
    state_nx   = state_q;
    busy_nx    = busy_q;
    done_nx    = 1'b0;
    cfg_err_nx = 1'b0;
    rd_en_nx   = 1'b0;
    rd_addr_nx = rd_addr_q;
    last_rd_nx = last_rd_q;
    last_wr_nx = last_wr_q;
    w_m1_nx    = w_m1_q;
    start_acc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            start_acc  = 1'b1;
            busy_nx    = 1'b1;
            rd_en_nx   = 1'b1;
            rd_addr_nx = '0;
            last_rd_nx = ADDR_W'(npix - 32'd1);
            last_wr_nx = ADDR_W'(32'(cfg_w - 16'd2) * 32'(cfg_h - 16'd2) - 32'd1);
            w_m1_nx    = CW'(cfg_w - 16'd1);
            state_nx   = RUN;
          end else begin
            cfg_err_nx = 1'b1;
          end
        end
      end
      RUN: begin
        if (rd_addr_q == last_rd_q) begin
          state_nx = DRAIN;
        end else begin
          rd_en_nx   = 1'b1;
          rd_addr_nx = rd_addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (wr_en && (wr_addr == last_wr_q)) begin
          done_nx  = 1'b1;
          state_nx = FIN;
        end
      end
      FIN: begin
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      last_rd_q <= '0;
      last_wr_q <= '0;
      w_m1_q    <= '0;
    end else begin
      state_q   <= state_nx;
      busy_q    <= busy_nx;
      done_q    <= done_nx;
      cfg_err_q <= cfg_err_nx;
      rd_en_q   <= rd_en_nx;
      rd_addr_q <= rd_addr_nx;
      last_rd_q <= last_rd_nx;
      last_wr_q <= last_wr_nx;
      w_m1_q    <= w_m1_nx;
    end
  end

  assign lb0_rd = lb0[col_q];
  assign lb1_rd = lb1[col_q];

  // Line buffers shift a column down one row each time a pixel lands
  always_ff @(posedge clk) begin
    if (cap_v) begin
      lb0[col_q] <= lb1_rd;
      lb1[col_q] <= rd_data;
    end
  end

  // Pixel capture, window shift and the result-index delay line
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cap_v       <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      win_idx_q   <= '0;
      win_cnt_q   <= '0;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
      for (int i = 0; i < int'(SOBEL_LAT); i++) begin
        dly_v[i]   <= 1'b0;
        dly_idx[i] <= '0;
      end
    end else begin
      cap_v       <= rd_en_q;
      win_valid_q <= 1'b0;
      if (start_acc) begin
        col_q     <= '0;
        row_q     <= '0;
        win_cnt_q <= '0;
      end else if (cap_v) begin
        win_q[0] <= win_q[1];
        win_q[1] <= win_q[2];
        win_q[2] <= lb0_rd;
        win_q[3] <= win_q[4];
        win_q[4] <= win_q[5];
        win_q[5] <= lb1_rd;
        win_q[6] <= win_q[7];
        win_q[7] <= win_q[8];
        win_q[8] <= rd_data;
        // Columns 0 and 1 still carry the previous row's tail, so they never qualify
        if ((row_q >= 16'd2) && (col_q >= CW'(2))) begin
          win_valid_q <= 1'b1;
          win_idx_q   <= win_cnt_q;
          win_cnt_q   <= win_cnt_q + ADDR_W'(1);
        end
        if (col_q == w_m1_q) begin
          col_q <= '0;
          row_q <= row_q + 16'd1;
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
      dly_v[0]   <= win_valid_q;
      dly_idx[0] <= win_idx_q;
      for (int i = 1; i < int'(SOBEL_LAT); i++) begin
        dly_v[i]   <= dly_v[i-1];
        dly_idx[i] <= dly_idx[i-1];
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign win_valid = win_valid_q;
  assign win_d0    = win_q[0];
  assign win_d1    = win_q[1];
  assign win_d2    = win_q[2];
  assign win_d3    = win_q[3];
  assign win_d4    = win_q[4];
  assign win_d5    = win_q[5];
  assign win_d6    = win_q[6];
  assign win_d7    = win_q[7];
  assign win_d8    = win_q[8];
  assign wr_en     = dly_v[SOBEL_LAT-1];
  assign wr_addr   = dly_idx[SOBEL_LAT-1];
  // The core result arrives in the write cycle itself, so the data path is a gated pass-through
  assign wr_data   = wr_en ? sobel_out : 8'd0;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Bench for sobel_frame_ctrl: frame RAM and Sobel core stand-ins, event monitor,
// and a frame-level reference model derived directly from the pixel array.
module tb_sobel_frame_ctrl;

  localparam int unsigned MAX_W  = 640;
  localparam int unsigned ADDR_W = 19;
  localparam int unsigned LAT    = 2;

  logic              clk = 1'b0;
  logic              rstn = 1'b1;
  logic              start = 1'b0;
  logic [15:0]       cfg_w = '0, cfg_h = '0;
  logic              busy, done, cfg_err, rd_en, win_valid, wr_en;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [7:0]        rd_data = '0;
  logic [7:0]        win_d0, win_d1, win_d2, win_d3, win_d4, win_d5, win_d6, win_d7, win_d8;
  logic [7:0]        sobel_out, wr_data;
  logic [7:0]        s1 = '0, s2 = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0]        src_mem [0:4095];
  int                fm      [0:4095];

  logic [ADDR_W-1:0] rd_a[$];
  int                rd_c[$];
  logic [71:0]       win_v[$];
  int                win_c[$];
  logic [ADDR_W-1:0] wr_a[$];
  logic [7:0]        wr_d[$];
  int                wr_c[$];
  int                done_c[$];
  int                cfg_err_n;
  int                busy_last;

  logic [6+2*ADDR_W+80-1:0] all_outs;
  assign all_outs = {busy, done, cfg_err, rd_en, win_valid, wr_en, rd_addr, wr_addr, wr_data,
                     win_d0, win_d1, win_d2, win_d3, win_d4, win_d5, win_d6, win_d7, win_d8};

  sobel_frame_ctrl #(.MAX_W(MAX_W), .ADDR_W(ADDR_W), .SOBEL_LAT(LAT)) dut (
    .clk(clk), .rstn(rstn), .start(start), .cfg_w(cfg_w), .cfg_h(cfg_h),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .win_valid(win_valid),
    .win_d0(win_d0), .win_d1(win_d1), .win_d2(win_d2), .win_d3(win_d3), .win_d4(win_d4),
    .win_d5(win_d5), .win_d6(win_d6), .win_d7(win_d7), .win_d8(win_d8),
    .sobel_out(sobel_out), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // |Gx| + |Gy| with saturation; p0..p8 row-major
  function automatic int sob(input int p0, p1, p2, p3, p4, p5, p6, p7, p8);
    int gx, gy, s;
    gx = (p2 + 2*p5 + p8) - (p0 + 2*p3 + p6);
    gy = (p6 + 2*p7 + p8) - (p0 + 2*p1 + p2);
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    s = gx + gy;
    if (p4 < 0) s = 0;
    return (s > 255) ? 255 : s;
  endfunction

  // Source RAM (one-cycle read) and a two-stage Sobel core
  always @(posedge clk) begin
    if (rd_en) rd_data <= src_mem[rd_addr[11:0]];
    s1 <= 8'(sob(int'(win_d0), int'(win_d1), int'(win_d2), int'(win_d3), int'(win_d4),
                 int'(win_d5), int'(win_d6), int'(win_d7), int'(win_d8)));
    s2 <= s1;
  end
  assign sobel_out = s2;

  always @(negedge clk) begin
    if (rd_en) begin rd_a.push_back(rd_addr); rd_c.push_back(cyc); end
    if (win_valid) begin
      win_v.push_back({win_d0, win_d1, win_d2, win_d3, win_d4, win_d5, win_d6, win_d7, win_d8});
      win_c.push_back(cyc);
    end
    if (wr_en) begin wr_a.push_back(wr_addr); wr_d.push_back(wr_data); wr_c.push_back(cyc); end
    if (done) done_c.push_back(cyc);
    if (cfg_err) cfg_err_n++;
    if (busy) busy_last = cyc;
  end

  task automatic clear_logs();
    rd_a.delete(); rd_c.delete(); win_v.delete(); win_c.delete();
    wr_a.delete(); wr_d.delete(); wr_c.delete(); done_c.delete();
    cfg_err_n = 0;
    busy_last = -1;
  endtask

  // mode 0: bottom row 10 else 0; 1: ramp; 2: constant 50; 3: random
  task automatic fill_frame(input int w, input int h, input int mode);
    int v;
    for (int i = 0; i < w*h; i++) begin
      case (mode)
        0:       v = (i / w == h - 1) ? 10 : 0;
        1:       v = i & 255;
        2:       v = 50;
        default: v = int'($urandom_range(0, 255));
      endcase
      fm[i] = v;
      src_mem[i] = 8'(v);
    end
  endtask

  function automatic int px(input int w, input int r, input int c);
    return fm[r*w + c];
  endfunction

  task automatic run_frame(input int w, input int h, input int mode, input bit repulse);
    int t0, dcyc, k, bad, et;
    int exp_r;
    logic [71:0] ew;
    bit got;
    fill_frame(w, h, mode);
    clear_logs();
    @(negedge clk);
    cfg_w = 16'(w); cfg_h = 16'(h); start = 1'b1; t0 = cyc;
    got = 1'b0; dcyc = -1;
    for (int n = 0; n < w*h + 100; n++) begin
      @(negedge clk);
      start = repulse && ((cyc - t0) == 4);
      if (done) begin got = 1'b1; dcyc = cyc - t0; start = repulse; break; end
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    checks++;
    if (!got) begin errors++; $display("FAIL done_timeout %0dx%0d: done not seen", w, h); end
    checks++;
    if (dcyc != w*h + 5) begin
      errors++; $display("FAIL done_cycle %0dx%0d: got %0d want %0d", w, h, dcyc, w*h + 5);
    end
    checks++;
    if (busy !== 1'b0 || busy_last != t0 + dcyc) begin
      errors++; $display("FAIL busy_end %0dx%0d: busy=%b last_high=%0d want low after %0d",
                         w, h, busy, busy_last - t0, dcyc);
    end
    checks++;
    if (rd_a.size() != w*h) begin
      errors++; $display("FAIL rd_count %0dx%0d: got %0d want %0d", w, h, rd_a.size(), w*h);
    end
    bad = 0;
    for (int i = 0; i < rd_a.size(); i++)
      if (rd_a[i] !== ADDR_W'(i) || rd_c[i] != t0 + 1 + i) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL rd_seq %0dx%0d: %0d reads out of order or off-cycle, want 0", w, h, bad);
    end
    exp_r = (w - 2) * (h - 2);
    checks++;
    if (win_v.size() != exp_r || wr_a.size() != exp_r) begin
      errors++; $display("FAIL out_count %0dx%0d: windows %0d writes %0d want %0d",
                         w, h, win_v.size(), wr_a.size(), exp_r);
    end
    k = 0;
    for (int r = 2; r < h; r++) begin
      for (int c = 2; c < w; c++) begin
        et = t0 + 3 + r*w + c;
        if (k < win_v.size()) begin
          for (int j = 0; j < 9; j++) ew[71 - 8*j -: 8] = 8'(px(w, r - 2 + j/3, c - 2 + j%3));
          checks++;
          if (win_v[k] !== ew || win_c[k] != et) begin
            errors++; $display("FAIL window[%0d] r%0d c%0d: got %h @%0d want %h @%0d",
                               k, r, c, win_v[k], win_c[k] - t0, ew, et - t0);
          end
        end
        if (k < wr_a.size()) begin
          exp_r = sob(px(w, r-2, c-2), px(w, r-2, c-1), px(w, r-2, c),
                      px(w, r-1, c-2), px(w, r-1, c-1), px(w, r-1, c),
                      px(w, r,   c-2), px(w, r,   c-1), px(w, r,   c));
          checks++;
          if (wr_a[k] !== ADDR_W'(k) || wr_d[k] !== 8'(exp_r) || wr_c[k] != et + LAT) begin
            errors++; $display("FAIL write[%0d]: got addr %0d data %0d @%0d want addr %0d data %0d @%0d",
                               k, wr_a[k], wr_d[k], wr_c[k] - t0, k, exp_r, et + LAT - t0);
          end
        end
        k++;
      end
    end
  endtask

  task automatic test_reset();
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (all_outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", all_outs); end
    repeat (3) @(negedge clk);
    checks++;
    if (all_outs !== '0) begin errors++; $display("FAIL reset_hold: got %h want 0", all_outs); end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_small_3x3();
    run_frame(3, 3, 0, 1'b0);
    checks++;
    if (wr_d.size() != 1 || wr_d[0] !== 8'd40) begin
      errors++; $display("FAIL small_wr_data: got %0d writes first %0d want 1 write of 40",
                         wr_d.size(), (wr_d.size() > 0) ? int'(wr_d[0]) : -1);
    end
  endtask

  task automatic test_ramp_5x4();
    logic [71:0] first;
    first = 72'h00_01_02_05_06_07_0A_0B_0C;
    run_frame(5, 4, 1, 1'b0);
    checks++;
    if (win_v.size() == 0 || win_v[0] !== first) begin
      errors++; $display("FAIL ramp_first_window: got %h want %h",
                         (win_v.size() > 0) ? win_v[0] : 72'h0, first);
    end
  endtask

  task automatic test_bad_cfg();
    int bw [4];
    int bh [4];
    bw = '{2, 5, MAX_W + 1, 640};
    bh = '{5, 2, 3, 820};
    for (int i = 0; i < 4; i++) begin
      clear_logs();
      @(negedge clk);
      cfg_w = 16'(bw[i]); cfg_h = 16'(bh[i]); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      checks++;
      if (cfg_err_n != 1 || busy_last != -1 || rd_a.size() != 0) begin
        errors++; $display("FAIL bad_cfg %0dx%0d: cfg_err cycles %0d busy_seen %0d reads %0d want 1 0 0",
                           bw[i], bh[i], cfg_err_n, (busy_last != -1) ? 1 : 0, rd_a.size());
      end
    end
  endtask

  task automatic test_back_to_back();
    run_frame(3, 3, 0, 1'b1);
    run_frame(3, 3, 0, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    fill_frame(5, 4, 1);
    clear_logs();
    @(negedge clk);
    cfg_w = 16'd5; cfg_h = 16'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    #1;
    checks++;
    if (rd_a.size() != 12) begin errors++; $display("FAIL mid_reads: got %0d want 12", rd_a.size()); end
    #1 rstn = 1'b0;
    #1;
    checks++;
    if (all_outs !== '0) begin errors++; $display("FAIL mid_reset_async: got %h want 0", all_outs); end
    clear_logs();
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (rd_a.size() != 0 || wr_a.size() != 0 || done_c.size() != 0) begin
      errors++; $display("FAIL mid_reset_quiet: reads %0d writes %0d done %0d want 0 0 0",
                         rd_a.size(), wr_a.size(), done_c.size());
    end
    rstn = 1'b1;
    run_frame(3, 3, 0, 1'b0);
  endtask

  task automatic test_random_frames();
    for (int i = 0; i < 4; i++)
      run_frame(int'($urandom_range(3, 12)), int'($urandom_range(3, 8)), 3, 1'b0);
  endtask

  task automatic test_max_width();
    run_frame(MAX_W, 3, 2, 1'b0);
    checks++;
    if (wr_a.size() == 0 || wr_a[wr_a.size()-1] !== ADDR_W'(MAX_W - 3)) begin
      errors++; $display("FAIL max_last_addr: got %0d want %0d",
                         (wr_a.size() > 0) ? int'(wr_a[wr_a.size()-1]) : -1, MAX_W - 3);
    end
  endtask

  initial begin
    clear_logs();
    test_reset();
    test_small_3x3();
    test_ramp_5x4();
    test_bad_cfg();
    test_back_to_back();
    test_reset_mid_run();
    test_random_frames();
    test_max_width();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/sobel_frame_ctrl.md
Name: sobel_frame_ctrl

Overview:
- Sequences the 3x3 Sobel datapath over one frame held in a source pixel RAM.
- On start: reads every pixel of a W x H frame in raster order and builds the 3x3 window with two internal line buffers plus window shift registers.
- Presents each complete window to the Sobel core as win_d0..win_d8, then writes the core's result to a destination RAM at the compacted (W-2)x(H-2) raster address.
- Sits between the frame RAMs and the Sobel core and owns all addressing and frame-level handshakes.

Parameters:
- MAX_W, 640, maximum supported frame width; sizes each line buffer (MAX_W x 8 bits).
- ADDR_W, 19, width of the source and destination RAM address buses.
- SOBEL_LAT, 2, cycles from win_valid to the matching valid result on sobel_out.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle frame start request; honoured only in IDLE.
- cfg_w  in  16  frame width W, sampled on an accepted start.
- cfg_h  in  16  frame height H, sampled on an accepted start.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse after the last result write.
- cfg_err  out  1  one-cycle pulse when start is rejected for bad configuration.
- rd_en  out  1  source RAM read strobe.
- rd_addr  out  ADDR_W  source RAM address.
- rd_data  in  8  source pixel; valid the cycle after rd_en.
- win_valid  out  1  window outputs hold a complete 3x3 neighbourhood.
- win_d0..win_d8  out  8 each  window pixels in row-major order; d0 = (r-2,c-2), d4 = (r-1,c-1), d8 = (r,c).
- sobel_out  in  8  result from the Sobel core.
- wr_en  out  1  destination RAM write strobe.
- wr_addr  out  ADDR_W  destination RAM address.
- wr_data  out  8  destination write data; equals sobel_out in the wr_en cycle.

Behaviour:
- Reset (asynchronous, any state):
  - busy, done, cfg_err, rd_en, win_valid and wr_en all 0.
  - rd_addr, wr_addr, wr_data and win_d* all 0.
  - State returns to IDLE; all counters clear; delay pipeline cleared.
  - Line-buffer contents are don't-care.
  - Reset asserted mid-frame drops the frame: no further writes and no done.
- States: IDLE, RUN, DRAIN, FIN.
- IDLE:
  - start with 3 <= cfg_w <= MAX_W, cfg_h >= 3, and cfg_w*cfg_h <= 2^ADDR_W: latch W and H, busy <= 1, go to RUN.
  - Otherwise, start: cfg_err pulses for 1 cycle and the block stays in IDLE.
- RUN:
  - rd_en high every cycle; rd_addr runs 0..W*H-1, one step per cycle.
  - After issuing address W*H-1, go to DRAIN.
  - start is ignored while busy.
- Pixel capture: the pixel read in cycle t is captured at the end of cycle t+1 with its column c and row r (raster counters, c wraps at W-1).
  - Line buffer 1 holds row r-1; line buffer 0 holds row r-2.
  - Each buffer is read and written at index c in the same cycle (read-before-write).
  - Window columns shift left by one; the new right column is {lb0[c], lb1[c], pixel}.
- Window output:
  - win_valid is high in cycle t+2 iff r >= 2 and c >= 2.
  - Window columns from the previous row do not leak: c = 0 and c = 1 never produce win_valid.
- Result path:
  - A SOBEL_LAT-deep delay line carries win_valid and the output index.
  - wr_en is high SOBEL_LAT cycles after each win_valid.
  - wr_addr = (r-2)*(W-2) + (c-2), incrementing from 0 to (W-2)*(H-2)-1; wr_data = sobel_out in that cycle.
- DRAIN: wait until the last wr_en has issued, then FIN.
- FIN: done = 1 for one cycle, busy <= 0, return to IDLE.
  - A start in the FIN cycle is ignored; start is accepted from the following IDLE cycle.
- Frame throughput: exactly W*H reads and (W-2)*(H-2) writes per frame.
- Arithmetic: address multiply/add in ADDR_W bits; no wrap within a legal frame.

Test Plan:
- 3x3 frame, rows {0,0,0},{0,0,0},{10,10,10}, behavioural Sobel core (LAT 2); start sampled in cycle 0 -> rd_en in cycles 1..9 with rd_addr 0..8, win_valid only in cycle 11, win_d6..d8 = 10, single wr_en in cycle 13 with wr_addr 0 and wr_data 40, done in cycle 14, busy low from cycle 15.
- W=5, H=4 ramp (pixel = address) -> 20 reads, exactly 6 writes with wr_addr 0..5 in order; first window d0..d8 = 0,1,2,5,6,7,10,11,12; no win_valid at c = 0 or c = 1 of any row.
- Bad configs: start with cfg_w=2, then cfg_h=2, then cfg_w=MAX_W+1 -> one cfg_err pulse each, busy stays 0, rd_en never asserts.
- start re-pulsed during RUN and in the done cycle -> ignored; the next start in IDLE runs a second 3x3 frame with identical timing.
- rstn deasserted mid-RUN of a 5x4 frame (after 12 reads) -> all outputs 0 asynchronously; after release, a new 3x3 frame completes correctly with wr_addr starting at 0.
- MAX_W-wide, 3-row frame of constant 50 -> MAX_W-2 writes, all wr_data 0, last wr_addr = MAX_W-3.
